prog_loader: RTL
================

Name: prog_loader

Overview:
- Boot-time program loader upstream of the CPU instruction memory.
- Accepts a byte stream (from a UART receiver or testbench) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a single-cycle write port.
- Holds the CPU in reset until the whole image has loaded and its checksum matches; then releases it.

Parameters:
- ADDR_WIDTH, 14, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word
- imem_addr  output  ADDR_WIDTH  word address of the write
- imem_wdata  output  32  word to write
- cpu_rst  output  1  active-low reset to the CPU; 0 holds the CPU in reset
- done  output  1  image loaded and verified; sticky
- error  output  1  load failed; sticky

Behaviour:
- Reset (rst==0 at a rising edge) applies to all state, including mid-load. After reset:
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, done=0, error=0
  - state=LEN, byte counter=0, word counter=0, checksum accumulator=0
- Stream format, in order:
  - 4 length bytes: N = word count, little-endian.
  - N*4 data bytes: words little-endian, first byte = bits[7:0].
  - 1 checksum byte: XOR of all preceding bytes (length and data).
- States:
  - LEN: rx_ready=1. Collect 4 bytes into N. On the 4th accepted byte:
    - N > 2^ADDR_WIDTH -> ERR
    - N==0 -> CSUM
    - otherwise -> DATA
  - DATA: rx_ready=1. Shift bytes into a 32-bit assembly register.
    - On the 4th byte of a word: in the next cycle imem_we=1, imem_addr=word counter, imem_wdata={b3,b2,b1,b0}; then the word counter increments.
    - After the last byte of word N-1 -> CSUM.
    - No stall: a new byte may be accepted in the same cycle imem_we is high.
  - CSUM: rx_ready=1. On the accepted byte, compare it with the accumulator:
    - equal -> DONE
    - not equal -> ERR
  - DONE: rx_ready=0, cpu_rst=1, done=1. Remains here until reset.
  - ERR: rx_ready=0, cpu_rst=0, error=1. Remains here until reset.
- Accumulator: XORs every accepted byte in LEN and DATA. The checksum byte itself is not accumulated.
- The byte counter (2 bits) wraps 3->0 per word.
- The word counter is ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH is legal. imem_addr takes its low ADDR_WIDTH bits.
- imem_we is registered and deasserts the cycle after its pulse. imem_addr and imem_wdata hold their last values between pulses.
- When rx_valid=0, all state holds. Arbitrary gaps between bytes are legal, with no timeout.
- cpu_rst, done and error are registered. cpu_rst rises in the same cycle done rises. done and error are never both 1.
- rx_valid in DONE or ERR is ignored.

Test Plan:
- Two-word load, stream 02 00 00 00 93 00 50 00 13 00 00 00 D2, rx_valid held high:
  - one imem_we pulse with addr 0, wdata 0x00500093
  - one imem_we pulse with addr 1, wdata 0x00000013
  - then done=1, cpu_rst=1, error=0, rx_ready=0
- Empty image, stream 00 00 00 00 00:
  - no imem_we pulse
  - done=1, cpu_rst=1
- Bad checksum, same stream as the two-word load but final byte D3:
  - both words still written
  - error=1, done=0, cpu_rst stays 0
  - further bytes are ignored (rx_ready=0)
- Overlength with ADDR_WIDTH=14, stream 01 40 00 00 (N=0x4001):
  - error=1 immediately after the 4th byte
  - no imem_we pulse
- Gapped delivery: two-word stream with rx_valid toggled 1/0 randomly, with gaps of 1-5 cycles:
  - identical writes and final done as the gapless run
- Reset mid-load: drop rst for one cycle after the 6th byte, then send the full two-word stream:
  - all outputs return to reset values
  - the load completes with addr 0 rewritten to 0x00500093 and done=1

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte
// stream into 32-bit words, writes them to instruction memory and releases the CPU.
module prog_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // Largest legal word count is the full memory, so compare in 33 bits.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [31:0]           len_full;
  logic [31:0]           word_full;
  logic [ADDR_WIDTH:0]   word_next;

  assign accept    = rx_valid && rx_ready_q;
  assign len_full  = {rx_data, len_q[31:8]};
  assign word_full = {rx_data, asm_q[31:8]};
  assign word_next = word_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_LEN: begin
        if (accept) begin
          len_d      = len_full;
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if ({1'b0, len_full} > CAPACITY) state_d = S_ERR;
            else if (len_full == 32'd0)      state_d = S_CSUM;
            else                             state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d      = word_full;
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            wdata_d    = word_full;
            word_cnt_d = word_next;
            if ({{(31-ADDR_WIDTH){1'b0}}, word_next} == len_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
    // Status outputs follow the next state so they change on the deciding edge.
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d     = (state_d == S_DONE);
    cpu_rst_d  = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
